// File: rtl/sha1_wb_pkg.sv
// Shared register map and FSM state encoding for the sha1_wb responder and its bus master.
package sha1_wb_pkg;

  localparam logic [31:0] OffNr     = 32'h0000_0000;
  localparam logic [31:0] OffId     = 32'h0000_0004;
  localparam logic [31:0] OffOps    = 32'h0000_0008;
  localparam logic [31:0] OffMsgIn  = 32'h0000_000C;
  localparam logic [31:0] OffDigest = 32'h0000_0010;

  localparam int unsigned OpsOnBit    = 0;
  localparam int unsigned OpsResetBit = 1;
  localparam int unsigned OpsPanicBit = 2;
  localparam int unsigned OpsDoneBit  = 3;

  localparam logic [31:0] CodeEbusy  = 32'hFFFF_FFF0;
  localparam logic [31:0] CodeEinval = 32'hFFFF_FFEA;
  localparam logic [31:0] CodeAck    = 32'h0000_0000;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StRstOp = 3'd1;
  localparam state_t StMsg   = 3'd2;
  localparam state_t StPoll  = 3'd3;
  localparam state_t StGap   = 3'd4;
  localparam state_t StDig   = 3'd5;
  localparam state_t StFin   = 3'd6;
  localparam state_t StErr   = 3'd7;

endpackage

// File: rtl/sha1_wb_xfer.sv
// Single Wishbone classic transfer engine: one request in, one ack or timeout out.
// After every ack or timeout cyc/stb stay low for at least one cycle before the next transfer.
module sha1_wb_xfer #(
  parameter int unsigned AckTimeout = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        timeout_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int unsigned TimerW = $clog2(AckTimeout + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(AckTimeout - 1);

  logic              active_q, active_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;

  assign ack_o     = active_q & wbm_ack_i;
  assign timeout_o = active_q & ~wbm_ack_i & (timer_q == TimerLast);
  assign rdata_o   = wbm_dat_i;

  always_comb begin
    active_d = active_q;
    timer_d  = timer_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    if (!active_q) begin
      // A request is only taken from idle, so the cycle after an ack is always bus-idle.
      if (req_i) begin
        active_d = 1'b1;
        timer_d  = '0;
        we_d     = we_i;
        adr_d    = adr_i;
        dat_d    = wdata_i;
      end
    end else if (ack_o || timeout_o) begin
      active_d = 1'b0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
    end else begin
      active_q <= active_d;
      timer_q  <= timer_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
    end
  end

  assign wbm_cyc_o = active_q;
  assign wbm_stb_o = active_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = active_q ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: rtl/sha1_wb_master.sv
// Sequencer that pushes one padded block through a sha1_wb responder and reads back the digest.
module sha1_wb_master
  import sha1_wb_pkg::*;
#(
  parameter logic [31:0] SLAVE_BASE  = 32'h3000_0024,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned MAX_POLLS   = 1023
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         start_i,
  input  logic [511:0] msg_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [159:0] digest_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  localparam int unsigned PollW = $clog2(MAX_POLLS + 1);
  localparam int unsigned GapW  = $clog2(POLL_GAP + 1);
  localparam logic [PollW-1:0] PollLimit = PollW'(MAX_POLLS);
  localparam logic [GapW-1:0]  GapLast   = GapW'(POLL_GAP - 1);

  state_t             state_q, state_d;
  logic [511:0]       msg_q, msg_d;
  logic [3:0]         widx_q, widx_d;
  logic [2:0]         didx_q, didx_d;
  logic [PollW-1:0]   poll_q, poll_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [159:0]       digest_q, digest_d;

  logic               req;
  logic               we;
  logic [31:0]        adr;
  logic [31:0]        wdata;
  logic               xfer_ack;
  logic               xfer_timeout;
  logic [31:0]        xfer_rdata;
  logic [PollW-1:0]   poll_inc;

  assign poll_inc = poll_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    widx_d   = widx_q;
    didx_d   = didx_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    digest_d = digest_q;
    req      = 1'b0;
    we       = 1'b0;
    adr      = SLAVE_BASE + OffOps;
    wdata    = '0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRstOp;
          msg_d   = msg_i;
          widx_d  = '0;
          didx_d  = '0;
          poll_d  = '0;
          gap_d   = '0;
        end
      end
      StRstOp: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = 32'(1) << OpsResetBit;
        if (xfer_ack) state_d = StMsg;
      end
      StMsg: begin
        req   = 1'b1;
        we    = 1'b1;
        adr   = SLAVE_BASE + OffMsgIn;
        wdata = msg_q[{widx_q, 5'b0} +: 32];
        if (xfer_ack) begin
          // The responder starts hashing on its own once the 16th word lands.
          if (widx_q == 4'd15) state_d = StPoll;
          else                 widx_d  = widx_q + 4'd1;
        end
      end
      StPoll: begin
        req = 1'b1;
        if (xfer_ack) begin
          if (xfer_rdata[OpsDoneBit])       state_d = StDig;
          else if (xfer_rdata[OpsPanicBit]) state_d = StErr;
          else                              state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          poll_d  = poll_inc;
          state_d = (poll_inc == PollLimit) ? StErr : StPoll;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDig: begin
        req = 1'b1;
        adr = SLAVE_BASE + OffDigest;
        if (xfer_ack) begin
          if (xfer_rdata == CodeEbusy) begin
            state_d = StErr;
          end else begin
            digest_d[{didx_q, 5'b0} +: 32] = xfer_rdata;
            if (didx_q == 3'd4) state_d = StFin;
            else                didx_d  = didx_q + 3'd1;
          end
        end
      end
      StFin:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (xfer_timeout) state_d = StErr;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= StIdle;
      msg_q    <= '0;
      widx_q   <= '0;
      didx_q   <= '0;
      poll_q   <= '0;
      gap_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      widx_q   <= widx_d;
      didx_q   <= didx_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      digest_q <= digest_d;
    end
  end

  sha1_wb_xfer #(
    .AckTimeout (ACK_TIMEOUT)
  ) u_xfer (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .req_i     (req),
    .we_i      (we),
    .adr_i     (adr),
    .wdata_i   (wdata),
    .ack_o     (xfer_ack),
    .rdata_o   (xfer_rdata),
    .timeout_o (xfer_timeout),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  assign busy_o   = (state_q != StIdle) && (state_q != StFin) && (state_q != StErr);
  assign done_o   = (state_q == StFin);
  assign err_o    = (state_q == StErr);
  assign digest_o = digest_q;

endmodule

// File: tb/tb_sha1_wb_master.sv
// Directed bench: sha1_wb_master against a behavioural sha1_wb responder with mute/no-done modes.
module tb_sha1_wb_master;
  import sha1_wb_pkg::*;

  localparam logic [31:0] Base = 32'h3000_0024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] msg = '0;
  logic         busy, done, err;
  logic [159:0] digest;
  logic         wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]   wbm_sel;
  logic [31:0]  wbm_adr, wbm_dat, wbm_rdat;

  always #5 clk = ~clk;

  sha1_wb_master dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .start_i   (start),
    .msg_i     (msg),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .digest_o  (digest),
    .wbm_cyc_o (wbm_cyc),
    .wbm_stb_o (wbm_stb),
    .wbm_we_o  (wbm_we),
    .wbm_sel_o (wbm_sel),
    .wbm_adr_o (wbm_adr),
    .wbm_dat_o (wbm_dat),
    .wbm_dat_i (wbm_rdat),
    .wbm_ack_i (wbm_ack)
  );

  function automatic logic [159:0] sha1_blk(input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {32'hC3D2E1F0 + e, 32'h10325476 + d, 32'h98BADCFE + c, 32'hEFCDAB89 + b,
            32'h67452301 + a};
  endfunction

  // Responder: 0 = normal, 1 = never acks, 2 = OPS never reports DONE.
  int           resp_mode = 0;
  logic         r_ack;
  logic [31:0]  r_dat;
  int           mcnt, dcnt, bcnt;
  logic         done_f;
  logic [511:0] macc;
  logic [159:0] hash;

  assign wbm_ack  = r_ack;
  assign wbm_rdat = r_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0; r_dat <= '0; mcnt <= 0; dcnt <= 0; bcnt <= 0;
      done_f <= 1'b0; macc <= '0; hash <= '0;
    end else begin
      r_ack <= 1'b0;
      if (bcnt == 1) begin done_f <= 1'b1; hash <= sha1_blk(macc); end
      if (bcnt != 0) bcnt <= bcnt - 1;
      if (wbm_cyc && wbm_stb && !r_ack && resp_mode != 1) begin
        r_ack <= 1'b1;
        r_dat <= '0;
        if (wbm_we) begin
          if (wbm_adr == Base + OffOps && wbm_dat[1]) begin
            mcnt <= 0; dcnt <= 0; bcnt <= 0; done_f <= 1'b0;
          end else if (wbm_adr == Base + OffMsgIn && mcnt < 16) begin
            macc[32*mcnt +: 32] <= wbm_dat;
            mcnt <= mcnt + 1;
            if (mcnt == 15) bcnt <= 30;
          end
        end else if (wbm_adr == Base + OffOps) begin
          r_dat <= {28'd0, done_f && resp_mode == 0, 3'd0};
        end else if (wbm_adr == Base + OffDigest) begin
          if (!done_f) r_dat <= CodeEbusy;
          else begin r_dat <= hash[32*dcnt +: 32]; dcnt <= dcnt + 1; end
        end
      end
    end
  end

  // Bus protocol monitor and event counters, sampled on the inactive edge.
  logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;
  int bus_err = 0, msg_wr = 0, dig_rd = 0, ops_reads = 0, ops_last = 0, ops_period = 0;
  int cyc_cnt = 0, stb_run = 0, last_run = 0, done_cnt = 0, err_cnt = 0;
  logic        first_pend = 1'b1, first_we = 1'b0;
  logic [31:0] first_adr = '0, first_dat = '0;
  logic        rise;
  assign rise = wbm_stb && !p_stb;

  always @(negedge clk) begin
    bus_err <= bus_err + int'(wbm_stb && !wbm_cyc) + int'(wbm_cyc && wbm_sel != 4'hF)
             + int'(p_stb && !p_ack && wbm_stb && ({wbm_adr, wbm_we, wbm_dat} != {p_adr, p_we, p_dat}))
             + int'(p_ack && wbm_cyc);
    p_stb <= wbm_stb; p_ack <= wbm_ack; p_we <= wbm_we; p_adr <= wbm_adr; p_dat <= wbm_dat;
    cyc_cnt <= cyc_cnt + 1;
    stb_run <= wbm_stb ? stb_run + 1 : 0;
    if (!wbm_stb && p_stb) last_run <= stb_run;
    if (wbm_stb && wbm_ack && wbm_we && wbm_adr == Base + OffMsgIn) msg_wr <= msg_wr + 1;
    if (wbm_stb && wbm_ack && !wbm_we && wbm_adr == Base + OffDigest) dig_rd <= dig_rd + 1;
    if (rise && !wbm_we && wbm_adr == Base + OffOps) begin
      ops_reads <= ops_reads + 1; ops_last <= cyc_cnt; ops_period <= cyc_cnt - ops_last;
    end
    if (!busy) first_pend <= 1'b1;
    else if (rise && first_pend) begin
      first_pend <= 1'b0; first_adr <= wbm_adr; first_dat <= wbm_dat; first_we <= wbm_we;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [511:0] m);
    @(negedge clk);
    msg = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && !err && n < bound);
  endtask

  logic [511:0] abc_blk, empty_blk;
  logic [159:0] abc_dig, empty_dig;
  int b_msg, b_dig, b_ops, b_done, b_err, n;

  initial begin
    abc_blk = '0; abc_blk[31:0] = 32'h6162_6380; abc_blk[511:480] = 32'h0000_0018;
    empty_blk = '0; empty_blk[31:0] = 32'h8000_0000;
    abc_dig   = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36};
    empty_dig = {32'hafd80709, 32'h95601890, 32'h3255bfef, 32'h5e6b4b0d, 32'hda39a3ee};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, err}, 3'b000);
    check("rst_digest", digest, 160'd0);
    check("rst_bus", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "abc" block
    b_msg = msg_wr; b_dig = dig_rd; b_ops = ops_reads;
    pulse_start(abc_blk);
    check("abc_busy", busy, 1'b1);
    wait_end(2000);
    check("abc_done", {done, err, busy}, 3'b100);
    check("abc_digest", digest, abc_dig);
    #1;
    check("abc_first_wr", {first_we, first_adr, first_dat}, {1'b1, Base + 32'h8, 32'h2});
    check("abc_msg_writes", msg_wr - b_msg, 16);
    check("abc_dig_reads", dig_rd - b_dig, 5);
    check("abc_polled", (ops_reads - b_ops) >= 2, 1'b1);
    check("abc_poll_period", ops_period, 7);
    @(negedge clk);
    check("abc_done_pulse", {done, busy}, 2'b00);

    // Empty block, with an extra start while busy that must be ignored
    b_msg = msg_wr; b_done = done_cnt;
    pulse_start(empty_blk);
    repeat (10) @(negedge clk);
    pulse_start(abc_blk);
    wait_end(2000);
    check("empty_done", done, 1'b1);
    check("empty_digest", digest, empty_dig);
    start = 1'b1; msg = abc_blk;  // coincides with done: ignored
    @(negedge clk);
    check("start_at_done_ignored", busy, 1'b0);
    msg = empty_blk;              // back-to-back start right after done
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    wait_end(2000);
    check("b2b_done", done, 1'b1);
    check("b2b_digest", digest, empty_dig);
    #1;
    check("b2b_done_count", done_cnt - b_done, 2);
    check("b2b_msg_writes", msg_wr - b_msg, 32);

    // Reset in the middle of the message phase
    b_msg = msg_wr;
    pulse_start(abc_blk);
    n = 0;
    while ((msg_wr - b_msg) < 5 && n < 500) begin @(negedge clk); n++; end
    check("mid_reached", (msg_wr - b_msg) >= 5, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {busy, done, err}, 3'b000);
    check("mid_rst_bus", {wbm_cyc, wbm_stb, wbm_sel}, '0);
    check("mid_rst_digest", digest, 160'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    b_done = done_cnt; b_err = err_cnt;
    repeat (20) @(negedge clk);
    #1;
    check("mid_no_pulse", {done_cnt - b_done, err_cnt - b_err}, 64'd0);
    check("mid_idle", busy, 1'b0);
    pulse_start(abc_blk);
    wait_end(2000);
    check("fresh_done", done, 1'b1);
    check("fresh_digest", digest, abc_dig);

    // Responder never acks
    resp_mode = 1;
    pulse_start(empty_blk);
    wait_end(200);
    check("to_err", {err, done}, 2'b10);
    check("to_idle", {wbm_cyc, wbm_stb, busy}, 3'b000);
    #1;
    check("to_stb_cycles", last_run, 16);
    @(negedge clk);
    check("to_err_pulse", err, 1'b0);

    // OPS never reports DONE
    resp_mode = 2;
    b_ops = ops_reads;
    pulse_start(abc_blk);
    wait_end(10000);
    check("poll_err", {err, done, busy, wbm_cyc}, 4'b1000);
    #1;
    check("poll_count", ops_reads - b_ops, 1023);
    check("poll_period", ops_period, 7);

    check("bus_protocol", bus_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
